// File: rtl/emmc_dat_rx_pkg.sv
// jedec_p: shared eMMC DAT-bus constants, bus-size and receiver state types.
package jedec_p;
    localparam int DAT_WIDTH = 8;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    typedef enum logic [1:0] {BUS_1B = 2'd0, BUS_4B = 2'd1, BUS_8B = 2'd2} bus_siz_t;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT_START, ST_DATA, ST_CRC, ST_END} emmc_dat_rx_state_t;
    function automatic logic [DAT_WIDTH-1:0] line_mask(input bus_siz_t b);
        return b == BUS_1B ? 8'h01 : b == BUS_4B ? 8'h0F : 8'hFF;
    endfunction
endpackage

// File: rtl/emmc_crc16.sv
// emmc_crc16: serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT line.
module emmc_crc16 import jedec_p::*; (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        din_i,
    output logic [15:0] crc_o
);
    logic [15:0] crc_q, crc_d;
    always_comb crc_d = {crc_q[14:0], 1'b0} ^ ((din_i ^ crc_q[15]) ? CRC16_POLY : 16'h0000);
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) crc_q <= '0;
        else if (en_i) crc_q <= crc_d;
    end
    assign crc_o = crc_q;
endmodule

// File: rtl/emmc_dat_rx.sv
// emmc_dat_rx: eMMC DAT receive stage (start bit, 1/4/8-bit deserialise, per-line CRC16, end bit).
// Define EMMC_DAT_RX_TIMEOUT_EN to abort with err_o after NAC_MAX cycles without a start bit.
module emmc_dat_rx import jedec_p::*; #(
    parameter int BLK_LEN = 512,
    parameter int NAC_MAX = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 arm_i,
    input  logic [15:0]          blk_cnt_i,
    input  logic [1:0]           bus_siz_i,
    input  logic                 abort_i,
    input  logic [DAT_WIDTH-1:0] emmc_dat_i,
    output logic [7:0]           dat_o,
    output logic                 dvalid_o,
    output logic                 blk_done_o,
    output logic                 crc_ok_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 busy_o
);
    localparam int BW = BLK_LEN > 1 ? $clog2(BLK_LEN) : 1;
    emmc_dat_rx_state_t state_q, state_d;
    bus_siz_t bsz_q, bsz_d;
    logic [15:0] rem_q, rem_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0] beat_q, beat_d;
    logic [3:0] ccnt_q, ccnt_d;
    logic [7:0] sh_q, sh_d, dat_q, dat_d, nxt;
    logic [DAT_WIDTH-1:0][15:0] rx_crc_q, rx_crc_d, calc_crc;
    logic dvalid_q, dvalid_d, blk_done_q, blk_done_d, crc_ok_q, crc_ok_d;
    logic done_q, done_d, err_q, err_d;
    logic [DAT_WIDTH-1:0] mask, line_ok;
    logic start, last_beat, crc_clr;
`ifdef EMMC_DAT_RX_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
`endif

    assign mask      = line_mask(bsz_q);
    assign start     = (emmc_dat_i & mask) == '0;
    assign last_beat = beat_q == (bsz_q == BUS_1B ? 3'd7 : bsz_q == BUS_4B ? 3'd1 : 3'd0);
    assign nxt       = bsz_q == BUS_1B ? {sh_q[6:0], emmc_dat_i[0]} :
                       bsz_q == BUS_4B ? {sh_q[3:0], emmc_dat_i[3:0]} : emmc_dat_i[7:0];
    assign crc_clr   = state_q == ST_WAIT_START && start;

    for (genvar g = 0; g < DAT_WIDTH; g++) begin : g_crc
        emmc_crc16 u_crc (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (crc_clr),
            .en_i  (state_q == ST_DATA && mask[g]),
            .din_i (emmc_dat_i[g]),
            .crc_o (calc_crc[g])
        );
        assign line_ok[g] = !mask[g] || (calc_crc[g] == rx_crc_q[g] && emmc_dat_i[g]);
    end

    always_comb begin
        state_d    = state_q;
        bsz_d      = bsz_q;
        rem_d      = rem_q;
        bcnt_d     = bcnt_q;
        beat_d     = beat_q;
        ccnt_d     = ccnt_q;
        sh_d       = sh_q;
        dat_d      = dat_q;
        rx_crc_d   = rx_crc_q;
        dvalid_d   = 1'b0;
        blk_done_d = 1'b0;
        crc_ok_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
`ifdef EMMC_DAT_RX_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            ST_IDLE: if (arm_i) begin
                state_d = ST_WAIT_START;
                bsz_d   = bus_siz_i == 2'd3 ? BUS_8B : bus_siz_t'(bus_siz_i);
                rem_d   = blk_cnt_i == 16'd0 ? 16'd1 : blk_cnt_i;
                err_d   = 1'b0;
`ifdef EMMC_DAT_RX_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ST_WAIT_START: if (start) begin
                state_d = ST_DATA;
                bcnt_d  = '0;
                beat_d  = '0;
            end else begin
`ifdef EMMC_DAT_RX_TIMEOUT_EN
                if (tmo_q == 16'(NAC_MAX - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else tmo_d = tmo_q + 16'd1;
`else
                state_d = ST_WAIT_START;
`endif
            end
            ST_DATA: begin
                sh_d   = nxt;
                beat_d = last_beat ? 3'd0 : beat_q + 3'd1;
                if (last_beat) begin
                    dat_d    = nxt;
                    dvalid_d = 1'b1;
                    bcnt_d   = bcnt_q + 1'b1;
                    if (bcnt_q == BW'(BLK_LEN - 1)) begin
                        state_d = ST_CRC;
                        ccnt_d  = '0;
                    end
                end
            end
            ST_CRC: begin
                for (int k = 0; k < DAT_WIDTH; k++) rx_crc_d[k] = {rx_crc_q[k][14:0], emmc_dat_i[k]};
                ccnt_d  = ccnt_q + 4'd1;
                state_d = ccnt_q == 4'd15 ? ST_END : ST_CRC;
            end
            ST_END: begin
                blk_done_d = 1'b1;
                crc_ok_d   = &line_ok;
                err_d      = err_q || !(&line_ok);
                rem_d      = rem_q - 16'd1;
                done_d     = rem_q == 16'd1;
                state_d    = rem_q == 16'd1 ? ST_IDLE : ST_WAIT_START;
`ifdef EMMC_DAT_RX_TIMEOUT_EN
                tmo_d      = '0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        // abort wins over every transition and swallows any strobe launched this cycle
        if (abort_i) begin
            state_d    = ST_IDLE;
            dvalid_d   = 1'b0;
            blk_done_d = 1'b0;
            crc_ok_d   = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            bsz_q      <= BUS_1B;
            rem_q      <= '0;
            bcnt_q     <= '0;
            beat_q     <= '0;
            ccnt_q     <= '0;
            sh_q       <= '0;
            dat_q      <= '0;
            rx_crc_q   <= '0;
            dvalid_q   <= 1'b0;
            blk_done_q <= 1'b0;
            crc_ok_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef EMMC_DAT_RX_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bsz_q      <= bsz_d;
            rem_q      <= rem_d;
            bcnt_q     <= bcnt_d;
            beat_q     <= beat_d;
            ccnt_q     <= ccnt_d;
            sh_q       <= sh_d;
            dat_q      <= dat_d;
            rx_crc_q   <= rx_crc_d;
            dvalid_q   <= dvalid_d;
            blk_done_q <= blk_done_d;
            crc_ok_q   <= crc_ok_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef EMMC_DAT_RX_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign dat_o      = dat_q;
    assign dvalid_o   = dvalid_q;
    assign blk_done_o = blk_done_q;
    assign crc_ok_o   = crc_ok_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign busy_o     = state_q != ST_IDLE;
endmodule

// File: tb/tb_emmc_dat_rx.sv
// tb_emmc_dat_rx: randomized scoreboard bench for emmc_dat_rx with a polynomial-division CRC reference.
module tb_emmc_dat_rx;
    import jedec_p::*;
    localparam int BLK = 512;

    logic clk = 1'b0, rst = 1'b1, arm = 1'b0, abort = 1'b0;
    logic [15:0] blk_cnt = '0;
    logic [1:0] bus_siz = '0;
    logic [DAT_WIDTH-1:0] dat_in = '1;
    logic [7:0] dat_o;
    logic dvalid_o, blk_done_o, crc_ok_o, done_o, err_o, busy_o;

    emmc_dat_rx #(.BLK_LEN(BLK), .NAC_MAX(16)) dut (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .blk_cnt_i(blk_cnt), .bus_siz_i(bus_siz),
        .abort_i(abort), .emmc_dat_i(dat_in), .dat_o(dat_o), .dvalid_o(dvalid_o),
        .blk_done_o(blk_done_o), .crc_ok_o(crc_ok_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {logic ok; logic last; logic err;} blk_exp_t;
    int compared = 0, mismatched = 0;
    logic [7:0] exp_bytes[$];
    blk_exp_t exp_blk[$];
    logic err_model = 1'b0, tmo_ok = 1'b0, mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // remainder of M(x)*x^16 mod G(x), computed by long division
    function automatic logic [15:0] crc_ref(input bit q[$]);
        logic [15:0] r = '0;
        bit top;
        for (int i = 0; i < q.size() + 16; i++) begin
            top = r[15];
            r = {r[14:0], i < q.size() ? q[i] : 1'b0};
            if (top) r ^= 16'h1021;
        end
        return r;
    endfunction

    always @(negedge clk) if (mon_en) begin
        if (dvalid_o) begin
            if (exp_bytes.size() == 0) chk("spurious dvalid", dvalid_o, 0);
            else chk("byte", dat_o, exp_bytes.pop_front());
        end
        if (blk_done_o) begin
            blk_exp_t e;
            if (exp_blk.size() == 0) chk("spurious blk_done", blk_done_o, 0);
            else begin
                e = exp_blk.pop_front();
                chk("crc_ok", crc_ok_o, e.ok);
                chk("done_with_blk", done_o, e.last);
                chk("err_at_blk", err_o, e.err);
            end
        end else if (done_o && !tmo_ok) chk("spurious done", done_o, 0);
    end

    function automatic int lines_of(input int bs);
        return bs == 0 ? 1 : bs == 1 ? 4 : 8;
    endfunction

    task automatic beat(input logic [7:0] v, input logic [7:0] m);
        dat_in = (v & m) | (8'($urandom) & ~m);
        @(posedge clk); #1;
    endtask

    task automatic arm_xfer(input int bs, input int nb);
        bus_siz = 2'(bs);
        blk_cnt = 16'(nb);
        arm = 1'b1;
        err_model = 1'b0;
        beat(8'hFF, 8'hFF);
        arm = 1'b0;
    endtask

    task automatic send_block(input int bs, input int mode, input int bi, input bit last,
                              input int fl, input int fb, input int ezl, input int stop_at, input bit use_rst);
        int L = lines_of(bs);
        int B = 8 / L;
        logic [7:0] m = 8'((1 << L) - 1);
        logic [7:0] data[BLK];
        logic [15:0] crc[8];
        bit lines[8][$];
        logic [7:0] v;
        bit ok;
        for (int i = 0; i < BLK; i++)
            data[i] = mode == 0 ? 8'hFF : mode == 1 ? 8'(bi * BLK + i) : mode == 3 ? 8'(i + 1) : 8'($urandom);
        repeat ($urandom_range(0, 4)) beat(8'hFF, m);
        beat(8'h00, m);
        for (int i = 0; i < BLK; i++) begin
            if (i == stop_at) begin
                if (use_rst) rst = 1'b1; else abort = 1'b1;
                beat(8'($urandom), m);
                rst = 1'b0;
                abort = 1'b0;
                return;
            end
            exp_bytes.push_back(data[i]);
            for (int j = 0; j < B; j++) begin
                v = '0;
                for (int k = 0; k < L; k++) begin
                    v[k] = data[i][8 - L * (j + 1) + k];
                    lines[k].push_back(v[k]);
                end
                beat(v, m);
            end
        end
        for (int k = 0; k < L; k++) crc[k] = crc_ref(lines[k]);
        if (fl >= 0) crc[fl][fb] = ~crc[fl][fb];
        for (int n = 15; n >= 0; n--) begin
            v = '0;
            for (int k = 0; k < L; k++) v[k] = crc[k][n];
            beat(v, m);
        end
        v = m;
        if (ezl >= 0) v[ezl] = 1'b0;
        ok = fl < 0 && ezl < 0;
        err_model = err_model || !ok;
        exp_blk.push_back('{ok, last, err_model});
        beat(v, m);
    endtask

    task automatic xfer(input int bs, input int nb, input int mode, input int bad_blk,
                        input int fl, input int fb, input int ezb, input int ezl);
        int n = nb == 0 ? 1 : nb;
        arm_xfer(bs, nb);
        for (int b = 0; b < n; b++)
            send_block(bs, mode, b, b == n - 1, b == bad_blk ? fl : -1, fb, b == ezb ? ezl : -1, -1, 1'b0);
        repeat (3) beat(8'hFF, 8'hFF);
        chk("drain", 32'(exp_bytes.size() + exp_blk.size()), 0);
        chk("busy_after", busy_o, 0);
        chk("err_sticky", err_o, err_model);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " dat_o"}, dat_o, 0);
        chk({nm, " dvalid"}, dvalid_o, 0);
        chk({nm, " blk_done"}, blk_done_o, 0);
        chk({nm, " crc_ok"}, crc_ok_o, 0);
        chk({nm, " done"}, done_o, 0);
        chk({nm, " err"}, err_o, 0);
        chk({nm, " busy"}, busy_o, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_zero("reset");
        mon_en = 1'b1;
        xfer(0, 1, 0, -1, -1, 0, -1, -1);
        xfer(2, 2, 1, -1, -1, 0, -1, -1);
        xfer(1, 2, 2, 0, 2, 0, -1, -1);
        xfer(2, 1, 2, -1, -1, 0, 0, 5);
        arm_xfer(1, 3);
        send_block(1, 3, 0, 1'b0, -1, 0, -1, 100, 1'b0);
        chk("abort busy", busy_o, 0);
        repeat (20) beat(8'hFF, 8'hFF);
        chk("abort drain", 32'(exp_bytes.size() + exp_blk.size()), 0);
        xfer(2, 1, 2, -1, -1, 0, -1, -1);
        arm_xfer(2, 1);
        send_block(2, 3, 0, 1'b1, -1, 0, -1, 50, 1'b1);
        chk_zero("midrst");
        repeat (5) beat(8'hFF, 8'hFF);
        chk("rst drain", 32'(exp_bytes.size() + exp_blk.size()), 0);
        for (int t = 0; t < 5; t++) begin
            int bs = $urandom_range(0, 3);
            int L = lines_of(bs);
            int nb = $urandom_range(0, 2);
            xfer(bs, nb, 2, $urandom_range(0, 2) == 0 ? 0 : -1, $urandom_range(0, L - 1),
                 $urandom_range(0, 15), $urandom_range(0, 3) == 0 ? 0 : -1, $urandom_range(0, L - 1));
        end
`ifdef EMMC_DAT_RX_TIMEOUT_EN
        begin
            int n = 0;
            tmo_ok = 1'b1;
            arm_xfer(2, 1);
            while (!done_o && n < 100) begin
                beat(8'hFF, 8'hFF);
                n++;
            end
            chk("timeout cycles", 32'(n), 16);
            chk("timeout err", err_o, 1);
            beat(8'hFF, 8'hFF);
            chk("timeout busy", busy_o, 0);
            tmo_ok = 1'b0;
        end
`else
        arm_xfer(0, 1);
        repeat (1000) beat(8'hFF, 8'hFF);
        chk("no-timeout busy", busy_o, 1);
        chk("no-timeout done", done_o, 0);
        abort = 1'b1;
        beat(8'hFF, 8'hFF);
        abort = 1'b0;
        chk("no-timeout abort busy", busy_o, 0);
`endif
        repeat (3) beat(8'hFF, 8'hFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/emmc_dat_rx.md
Name: emmc_dat_rx

Overview:
- Receive stage on the eMMC DAT bus. It sits between the DAT pin input and the host-side read data path of emmc_sm.
- Per block it:
  - detects the start bit;
  - deserialises data in 1/4/8-bit bus modes into bytes;
  - checks the per-line CRC16 and the end bit;
  - repeats for a programmed block count.
- emmc_sm arms it for read transfers and consumes its byte stream and status.

Parameters:
- BLK_LEN, 512, bytes per block (power of two, 1..4096)
- NAC_MAX, 65535, max clocks waiting for start bit (timeout feature only)

Ports:
- clk_i  in  1  core clock, also the eMMC sampling clock
- rst_i  in  1  synchronous active-high reset
- arm_i  in  1  one-cycle pulse; starts a read of blk_cnt_i blocks; accepted only in IDLE
- blk_cnt_i  in  16  block count latched on arm_i; 0 is treated as 1
- bus_siz_i  in  2  latched on arm_i: 0=1-bit (DAT0), 1=4-bit (DAT3:0), 2=8-bit; 3 is treated as 8-bit
- abort_i  in  1  forces IDLE next cycle, no done_o
- emmc_dat_i  in  jedec_p::DAT_WIDTH  sampled DAT lines
- dat_o  out  8  received byte, MSB first on the wire
- dvalid_o  out  1  one-cycle strobe per byte
- blk_done_o  out  1  one-cycle pulse after each block's end bit
- crc_ok_o  out  1  valid with blk_done_o: all active-line CRCs matched and the end bit was 1
- done_o  out  1  one-cycle pulse after the last block
- err_o  out  1  sticky until next arm_i: any block failed CRC/end bit, or timeout
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0.
- Latching on arm_i:
  - Active lines L = 1, 4 or 8.
  - Beats per byte = 8/L.
- States: IDLE -> WAIT_START -> DATA -> CRC -> END -> (WAIT_START | IDLE).
- WAIT_START:
  - Start bit = all active lines 0 in one cycle; next cycle enters DATA.
  - Inactive lines are ignored.
- DATA:
  - Each cycle shifts L bits into the byte register.
  - Bit mapping per beat:
    - 8-bit: DATk = bit k.
    - 4-bit: DAT3:0 carry the high nibble first, then the low nibble.
    - 1-bit: DAT0 carries bits 7..0.
  - dat_o/dvalid_o are asserted the cycle after the last beat of each byte.
  - Throughput: 1, 2 or 8 cycles per byte.
  - After BLK_LEN bytes -> CRC.
- CRC:
  - 16 cycles; each active line's bit is shifted into that line's received-CRC register, MSB first.
- END:
  - One cycle; samples the end bit on active lines.
  - Compares computed vs received CRC on every active line.
  - Pulses blk_done_o with crc_ok_o.
  - Sets err_o on mismatch.
  - Decrements the remaining count: nonzero -> WAIT_START; zero -> IDLE with done_o pulse in the same cycle as the final blk_done_o.
- CRC16:
  - Polynomial x^16+x^12+x^5+1, init 0, one generator per DAT line.
  - Each generator is fed only that line's data bits.
  - Generators clear on entry to DATA.
- A failed block does not stop the transfer; remaining blocks are still received.
- Simultaneous events:
  - arm_i outside IDLE is ignored.
  - abort_i has priority over all transitions; a final dvalid_o pending in that cycle is suppressed.
- rst_i mid-transfer returns to the reset state on the next edge; partial bytes are discarded.
- dvalid_o never asserts in WAIT_START/CRC/END except for the last data byte's delayed strobe on the first CRC cycle.

Optional Feature:
- Macro: EMMC_DAT_RX_TIMEOUT_EN.
- Defined:
  - WAIT_START counts cycles.
  - Reaching NAC_MAX without a start bit sets err_o, pulses done_o and returns to IDLE.
  - The counter restarts for every block.
- Undefined:
  - WAIT_START waits indefinitely (until abort_i/rst_i).
  - NAC_MAX is unused.

Decomposition:
- jedec_p holds:
  - DAT_WIDTH;
  - bus-size enum (BUS_1B=0, BUS_4B=1, BUS_8B=2);
  - CRC16 polynomial constant;
  - state enum type emmc_dat_rx_state_t.
- Sub-module emmc_crc16: serial 1-bit CRC16 with clr/en/din and 16-bit crc_o. It is instantiated DAT_WIDTH times via generate, and enables are gated by the active-line mask.

Test Plan:
- 1-bit, blk_cnt=1, BLK_LEN=512 bytes of 0xFF, CRC 0x7FA1, end bit 1 -> 512 dvalid_o strobes every 8 cycles, dat_o=0xFF, blk_done_o with crc_ok_o=1, done_o same cycle, err_o=0.
- 8-bit, blk_cnt=2, incrementing bytes 0x00..0xFF repeating, correct per-line CRCs -> dvalid_o every cycle, 1024 bytes in order, two blk_done_o with crc_ok_o=1, one done_o.
- 4-bit, block 1 with received CRC on DAT2 flipped in bit 0 -> block 1 crc_ok_o=0, err_o=1 and held; block 2 still received with crc_ok_o=1; done_o asserted.
- 8-bit, end bit 0 on DAT5 only with correct CRCs -> crc_ok_o=0, err_o=1.
- abort_i asserted at byte 100 of block 1 -> IDLE next cycle, busy_o=0, no further dvalid_o, no done_o; a subsequent arm_i works normally. Repeat with rst_i mid-DATA -> all outputs 0.
- With EMMC_DAT_RX_TIMEOUT_EN, NAC_MAX=16, DAT held high -> done_o and err_o=1 on cycle 16 after arm_i. Without the macro, busy_o stays 1 after 1000 cycles.
